// File: rtl/servo_loop_sequencer.sv
// Servo control-loop scheduler: periodic serial ADC read, PID start/done handshake, duty saturation.
// Optional LEADZERO_CHECK_EN adds a sticky lead_err flag for frames whose leading bits are not zero.
module servo_loop_sequencer #(
  parameter int CLK_DIV       = 2,
  parameter int SAMPLE_PERIOD = 2000,
  parameter int PID_TIMEOUT   = 64
) (
  input  logic               Clock_Nexys,
  input  logic               Reset,
  input  logic               start,
  input  logic               data_ADC,
  output logic               CS,
  output logic               Clock_Muestreo,
  output logic [11:0]        adc_sample,
  output logic               sample_valid,
  output logic               pid_start,
  input  logic               pid_done,
  input  logic signed [17:0] IPD,
  output logic [11:0]        duty,
  output logic               duty_valid,
  output logic               busy,
  output logic               overrun_err,
  output logic               timeout_err
`ifdef LEADZERO_CHECK_EN
  ,
  output logic               lead_err
`endif
);

  localparam int TW = $clog2(SAMPLE_PERIOD + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV + 1) : 1;
  localparam int OW = $clog2(PID_TIMEOUT + 1);
`ifdef LEADZERO_CHECK_EN
  localparam int SHW = 15;
`else
  localparam int SHW = 11;
`endif

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_TICK = 2'd1,
    S_CONVERT   = 2'd2,
    S_PID_WAIT  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [TW-1:0]   r_tick_cnt;
  logic [DW-1:0]   r_div;
  logic [4:0]      r_half;
  logic [SHW-1:0]  r_shift;
  logic [OW-1:0]   r_to;
  logic            r_start_d;

  logic            w_tick;
  logic            w_edge;
  logic            w_last;
  logic            w_lead_bad;
  logic            w_pid_to;
  logic [11:0]     w_sample;

  function automatic logic [11:0] sat_duty(input logic signed [17:0] v);
    if (v < 18'sd0)
      return 12'd0;
    else if (v > 18'sd4095)
      return 12'hFFF;
    else
      return v[11:0];
  endfunction

  assign w_tick   = (r_state != S_IDLE) && start && (r_tick_cnt == TW'(SAMPLE_PERIOD - 1));
  assign w_edge   = (r_state == S_CONVERT) && (r_div == DW'(CLK_DIV - 1));
  // Toggle 32 is the 16th rising edge: last data bit, frame ends.
  assign w_last   = w_edge && (r_half == 5'd31);
  assign w_pid_to = (r_to == OW'(PID_TIMEOUT - 1));
  assign w_sample = {r_shift[10:0], data_ADC};
  assign busy     = (r_state == S_CONVERT) || (r_state == S_PID_WAIT);

`ifdef LEADZERO_CHECK_EN
  assign w_lead_bad = |r_shift[14:11];
`else
  assign w_lead_bad = 1'b0;
`endif

  always_ff @(posedge Clock_Nexys or negedge Reset) begin
    if (!Reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!start) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:      w_next = S_WAIT_TICK;
        S_WAIT_TICK: if (w_tick) w_next = S_CONVERT;
        S_CONVERT:   if (w_last) w_next = w_lead_bad ? S_WAIT_TICK : S_PID_WAIT;
        S_PID_WAIT:  if (pid_done || w_pid_to) w_next = S_WAIT_TICK;
        default:     w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock_Nexys or negedge Reset) begin
    if (!Reset) begin
      CS             <= 1'b1;
      Clock_Muestreo <= 1'b1;
      adc_sample     <= 12'd0;
      duty           <= 12'd0;
      sample_valid   <= 1'b0;
      pid_start      <= 1'b0;
      duty_valid     <= 1'b0;
      overrun_err    <= 1'b0;
      timeout_err    <= 1'b0;
`ifdef LEADZERO_CHECK_EN
      lead_err       <= 1'b0;
`endif
      r_tick_cnt     <= '0;
      r_div          <= '0;
      r_half         <= '0;
      r_shift        <= '0;
      r_to           <= '0;
      r_start_d      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      pid_start    <= 1'b0;
      duty_valid   <= 1'b0;
      r_start_d    <= start;

      // Tick counter free-runs outside IDLE so dropped ticks keep the period.
      if (!start || r_state == S_IDLE || w_tick)
        r_tick_cnt <= '0;
      else
        r_tick_cnt <= r_tick_cnt + TW'(1);

      if (!start) begin
        CS             <= 1'b1;
        Clock_Muestreo <= 1'b1;
        r_div          <= '0;
        r_half         <= '0;
        r_to           <= '0;
      end else begin
        case (r_state)
          S_WAIT_TICK: begin
            if (w_tick) begin
              CS             <= 1'b0;
              Clock_Muestreo <= 1'b1;
              r_div          <= '0;
              r_half         <= '0;
            end
          end
          S_CONVERT: begin
            if (w_edge) begin
              r_div  <= '0;
              r_half <= r_half + 5'd1;
              if (!r_half[0]) begin
                Clock_Muestreo <= 1'b0;
              end else begin
                Clock_Muestreo <= 1'b1;
                r_shift        <= {r_shift[SHW-2:0], data_ADC};
              end
              if (w_last) begin
                CS   <= 1'b1;
                r_to <= '0;
                if (!w_lead_bad) begin
                  adc_sample   <= w_sample;
                  sample_valid <= 1'b1;
                  pid_start    <= 1'b1;
                end
              end
            end else begin
              r_div <= r_div + DW'(1);
            end
          end
          S_PID_WAIT: begin
            if (pid_done) begin
              duty       <= sat_duty(IPD);
              duty_valid <= 1'b1;
            end else if (w_pid_to) begin
              timeout_err <= 1'b1;
            end else begin
              r_to <= r_to + OW'(1);
            end
          end
          default: ;
        endcase
      end

`ifdef LEADZERO_CHECK_EN
      if (w_last && w_lead_bad)
        lead_err <= 1'b1;
`endif

      // A rising start can only happen from IDLE, so no set can collide with the clear.
      if (start && !r_start_d) begin
        overrun_err <= 1'b0;
        timeout_err <= 1'b0;
`ifdef LEADZERO_CHECK_EN
        lead_err    <= 1'b0;
`endif
      end else if (w_tick && r_state != S_WAIT_TICK) begin
        overrun_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_servo_loop_sequencer.sv
// Directed bench for servo_loop_sequencer: ADC serial model, PID responder model and
// a second instance with a short sample period for the overrun case.
module tb_servo_loop_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        data_adc;
  logic        pid_done;
  logic [17:0] ipd;
  logic        cs, cm, sv, ps, dv, busy, ovr, tmo;
  logic [11:0] adc, duty;
  logic        start2;
  logic        cs2, cm2, sv2, ps2, dv2, busy2, ovr2, tmo2;
  logic [11:0] adc2, duty2;
`ifdef LEADZERO_CHECK_EN
  logic        lead, lead2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  servo_loop_sequencer #(.CLK_DIV(1), .SAMPLE_PERIOD(100), .PID_TIMEOUT(64)) u_dut (
    .Clock_Nexys(clk), .Reset(rst_n), .start(start), .data_ADC(data_adc),
    .CS(cs), .Clock_Muestreo(cm), .adc_sample(adc), .sample_valid(sv),
    .pid_start(ps), .pid_done(pid_done), .IPD(ipd), .duty(duty),
    .duty_valid(dv), .busy(busy), .overrun_err(ovr), .timeout_err(tmo)
`ifdef LEADZERO_CHECK_EN
    , .lead_err(lead)
`endif
  );

  servo_loop_sequencer #(.CLK_DIV(1), .SAMPLE_PERIOD(20), .PID_TIMEOUT(64)) u_ovr (
    .Clock_Nexys(clk), .Reset(rst_n), .start(start2), .data_ADC(1'b0),
    .CS(cs2), .Clock_Muestreo(cm2), .adc_sample(adc2), .sample_valid(sv2),
    .pid_start(ps2), .pid_done(1'b1), .IPD(18'd0), .duty(duty2),
    .duty_valid(dv2), .busy(busy2), .overrun_err(ovr2), .timeout_err(tmo2)
`ifdef LEADZERO_CHECK_EN
    , .lead_err(lead2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ADC model: next bit presented after each falling serial clock.
  logic [15:0] adc_word = 16'h0ABC;
  int          bidx = 0;
  always @(negedge cs) bidx = 0;
  always @(negedge cm) begin
    if (bidx < 16) data_adc = adc_word[15 - bidx];
    bidx = bidx + 1;
  end

  // PID model: mode 0 answers 2 clocks after pid_start, mode 1 never answers.
  int pid_mode = 0;
  int pend = 0;
  always @(negedge clk) begin
    pid_done = 1'b0;
    if (pend == 1) pid_done = 1'b1;
    if (pend > 0) pend = pend - 1;
    if (ps && pid_mode == 0) pend = 2;
  end

  int sv_cnt = 0, dv_cnt = 0, ps_cnt = 0, cs_run = 0, last_cs = 0;
  int run2 = 0, frames2 = 0, bad2 = 0;
  always @(negedge clk) begin
    if (sv) sv_cnt = sv_cnt + 1;
    if (dv) dv_cnt = dv_cnt + 1;
    if (ps) ps_cnt = ps_cnt + 1;
    if (!cs) cs_run = cs_run + 1;
    else begin
      if (cs_run != 0) last_cs = cs_run;
      cs_run = 0;
    end
    if (!cs2) run2 = run2 + 1;
    else begin
      if (run2 != 0) begin
        frames2 = frames2 + 1;
        if (run2 != 32) bad2 = bad2 + 1;
      end
      run2 = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_dv(input int bound, input string nm);
    int c0;
    int i;
    c0 = dv_cnt;
    i = 0;
    while (dv_cnt == c0 && i < bound) begin tick(); i++; end
    n_tests++;
    if (dv_cnt == c0) begin n_fail++; $display("FAIL %s: no duty_valid within %0d cycles", nm, bound); end
  endtask

  task automatic wait_sv(input int bound, input string nm);
    int c0;
    int i;
    c0 = sv_cnt;
    i = 0;
    while (sv_cnt == c0 && i < bound) begin tick(); i++; end
    n_tests++;
    if (sv_cnt == c0) begin n_fail++; $display("FAIL %s: no sample_valid within %0d cycles", nm, bound); end
  endtask

  task automatic wait_cs(input logic lvl, input int bound, input string nm);
    int i;
    i = 0;
    while (cs !== lvl && i < bound) begin tick(); i++; end
    n_tests++;
    if (cs !== lvl) begin n_fail++; $display("FAIL %s: CS never reached %0b", nm, lvl); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; ipd = 18'd1234; data_adc = 1'b0;
    repeat (3) tick();
    n_tests++; if (cs !== 1'b1) begin n_fail++; $display("FAIL reset_cs: got %b want 1", cs); end
    n_tests++; if (cm !== 1'b1) begin n_fail++; $display("FAIL reset_clk: got %b want 1", cm); end
    n_tests++; if (adc !== 12'd0) begin n_fail++; $display("FAIL reset_adc: got %h want 000", adc); end
    n_tests++; if (duty !== 12'd0) begin n_fail++; $display("FAIL reset_duty: got %h want 000", duty); end
    n_tests++;
    if ({sv, ps, dv, busy, ovr, tmo} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000000", {sv, ps, dv, busy, ovr, tmo});
    end
    rst_n = 1'b1;
    repeat (3) tick();
    n_tests++; if (cs !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_hold: cs=%b busy=%b want 1/0", cs, busy); end
  endtask

  task automatic test_basic();
    int n;
    adc_word = 16'h0ABC; ipd = 18'd1234; pid_mode = 0;
    start = 1'b1;
    n = 0;
    while (cs !== 1'b0 && n < 200) begin tick(); n++; end
    n_tests++; if (n != 101) begin n_fail++; $display("FAIL first_tick: CS fell after %0d clocks want 101", n); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_convert: got %b want 1", busy); end
    wait_dv(120, "basic_dv");
    n_tests++; if (adc !== 12'hABC) begin n_fail++; $display("FAIL basic_adc: got %h want abc", adc); end
    n_tests++; if (duty !== 12'd1234) begin n_fail++; $display("FAIL basic_duty: got %0d want 1234", duty); end
    n_tests++; if (sv_cnt != 1 || ps_cnt != 1 || dv_cnt != 1) begin
      n_fail++; $display("FAIL basic_pulses: sv=%0d ps=%0d dv=%0d want 1/1/1", sv_cnt, ps_cnt, dv_cnt);
    end
    n_tests++; if (last_cs != 32) begin n_fail++; $display("FAIL basic_cs_len: got %0d want 32", last_cs); end
    n_tests++; if (ovr !== 1'b0 || tmo !== 1'b0) begin n_fail++; $display("FAIL basic_flags: ovr=%b tmo=%b want 0/0", ovr, tmo); end
  endtask

  task automatic test_saturation();
    ipd = 18'h3FFFB;
    wait_dv(200, "sat_neg_dv");
    n_tests++; if (duty !== 12'd0) begin n_fail++; $display("FAIL sat_neg: got %0d want 0", duty); end
    ipd = 18'd4095;
    wait_dv(200, "sat_edge_dv");
    n_tests++; if (duty !== 12'd4095) begin n_fail++; $display("FAIL sat_edge: got %0d want 4095", duty); end
    ipd = 18'd5000;
    wait_dv(200, "sat_big_dv");
    n_tests++; if (duty !== 12'd4095) begin n_fail++; $display("FAIL sat_big: got %0d want 4095", duty); end
  endtask

  task automatic test_timeout();
    int n;
    int dv0;
    pid_mode = 1;
    dv0 = dv_cnt;
    wait_sv(200, "to_sv");
    n = 0;
    while (tmo !== 1'b1 && n < 100) begin tick(); n++; end
    n_tests++; if (n != 64) begin n_fail++; $display("FAIL timeout_len: took %0d clocks want 64", n); end
    n_tests++; if (duty !== 12'd4095 || dv_cnt != dv0) begin
      n_fail++; $display("FAIL timeout_duty: duty=%0d dv_pulses=%0d want 4095/0", duty, dv_cnt - dv0);
    end
    pid_mode = 0; ipd = 18'd100;
    wait_dv(200, "to_recover_dv");
    n_tests++; if (duty !== 12'd100) begin n_fail++; $display("FAIL timeout_recover: got %0d want 100", duty); end
    n_tests++; if (tmo !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b want 1", tmo); end
  endtask

  task automatic test_start_drop();
    int n;
    int edges;
    int sv0;
    logic prev;
    wait_cs(1'b0, 200, "drop_cs_low");
    prev = cm; edges = 0; n = 0;
    while (edges < 8 && n < 40) begin
      tick(); n++;
      if (cm !== prev) edges++;
      prev = cm;
    end
    sv0 = sv_cnt;
    start = 1'b0;
    tick();
    n_tests++; if (cs !== 1'b1 || cm !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL drop_idle: cs=%b clk=%b busy=%b want 1/1/0", cs, cm, busy);
    end
    repeat (40) tick();
    n_tests++; if (sv_cnt != sv0) begin n_fail++; $display("FAIL drop_no_sv: got %0d extra want 0", sv_cnt - sv0); end
    n_tests++; if (adc !== 12'hABC || duty !== 12'd100) begin
      n_fail++; $display("FAIL drop_hold: adc=%h duty=%0d want abc/100", adc, duty);
    end
    n_tests++; if (tmo !== 1'b1) begin n_fail++; $display("FAIL drop_flag_held: got %b want 1", tmo); end
    adc_word = 16'h0123; ipd = 18'd777;
    start = 1'b1;
    tick();
    n_tests++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL restart_clear: got %b want 0", tmo); end
    n = 1;
    while (cs !== 1'b0 && n < 200) begin tick(); n++; end
    n_tests++; if (n != 101) begin n_fail++; $display("FAIL restart_tick: CS fell after %0d clocks want 101", n); end
    wait_dv(100, "restart_dv");
    n_tests++; if (adc !== 12'h123 || duty !== 12'd777) begin
      n_fail++; $display("FAIL restart_frame: adc=%h duty=%0d want 123/777", adc, duty);
    end
    n_tests++; if (last_cs != 32) begin n_fail++; $display("FAIL restart_cs_len: got %0d want 32", last_cs); end
  endtask

  task automatic test_overrun();
    start2 = 1'b1;
    repeat (200) tick();
    n_tests++; if (ovr2 !== 1'b1) begin n_fail++; $display("FAIL overrun_flag: got %b want 1", ovr2); end
    n_tests++; if (bad2 != 0) begin n_fail++; $display("FAIL overrun_cs_shape: %0d malformed CS pulses want 0", bad2); end
    n_tests++; if (frames2 < 3) begin n_fail++; $display("FAIL overrun_frames: got %0d want >=3", frames2); end
    n_tests++; if (tmo2 !== 1'b0) begin n_fail++; $display("FAIL overrun_tmo: got %b want 0", tmo2); end
  endtask

`ifdef LEADZERO_CHECK_EN
  task automatic test_lead();
    int ps0;
    int sv0;
    adc_word = 16'h4ABC;
    ps0 = ps_cnt; sv0 = sv_cnt;
    wait_cs(1'b0, 200, "lead_cs_low");
    wait_cs(1'b1, 60, "lead_cs_high");
    repeat (4) tick();
    n_tests++; if (lead !== 1'b1) begin n_fail++; $display("FAIL lead_flag: got %b want 1", lead); end
    n_tests++; if (ps_cnt != ps0 || sv_cnt != sv0) begin
      n_fail++; $display("FAIL lead_suppress: ps=%0d sv=%0d extra want 0/0", ps_cnt - ps0, sv_cnt - sv0);
    end
    n_tests++; if (adc !== 12'h123) begin n_fail++; $display("FAIL lead_adc_hold: got %h want 123", adc); end
  endtask
`endif

  task automatic test_reset_midframe();
    wait_cs(1'b0, 200, "mid_cs_low");
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    n_tests++; if (cs !== 1'b1 || cm !== 1'b1) begin n_fail++; $display("FAIL async_reset_pins: cs=%b clk=%b want 1/1", cs, cm); end
    n_tests++; if (adc !== 12'd0 || duty !== 12'd0) begin
      n_fail++; $display("FAIL async_reset_regs: adc=%h duty=%h want 000/000", adc, duty);
    end
    n_tests++; if (busy !== 1'b0 || ovr2 !== 1'b0) begin n_fail++; $display("FAIL async_reset_flags: busy=%b ovr=%b want 0/0", busy, ovr2); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_timeout();
    test_start_drop();
    test_overrun();
`ifdef LEADZERO_CHECK_EN
    test_lead();
`endif
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/servo_loop_sequencer.md
Name: servo_loop_sequencer

Overview:
- Control-loop scheduler for the servo datapath.
- Every SAMPLE_PERIOD clocks it runs one 16-clock serial read of the 12-bit position ADC (CS / Clock_Muestreo / data_ADC), hands the sample to the PID block through a start/done handshake, then saturates the 18-bit IPD result into the 12-bit PWM duty register.
- Sits between the ADC pins, the PID core and the PWM generator inside Servo_Top.

Parameters:
- CLK_DIV, 2: system clocks per Clock_Muestreo half-period (≥1).
- SAMPLE_PERIOD, 2000: system clocks between sample ticks (must exceed 32*CLK_DIV+PID_TIMEOUT+4).
- PID_TIMEOUT, 64: maximum clocks to wait for pid_done.

Ports:
- Clock_Nexys  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset (asserted at 0).
- start  in  1  loop enable; low forces IDLE.
- data_ADC  in  1  ADC serial data, MSB first.
- CS  out  1  ADC chip select, active low.
- Clock_Muestreo  out  1  ADC serial clock, idles high.
- adc_sample  out  12  last captured sample.
- sample_valid  out  1  one-cycle pulse, adc_sample updated.
- pid_start  out  1  one-cycle request to PID.
- pid_done  in  1  PID result ready (IPD valid this cycle).
- IPD  in  18  PID output, two's complement.
- duty  out  12  PWM duty register.
- duty_valid  out  1  one-cycle pulse, duty updated.
- busy  out  1  high in CONVERT/PID_WAIT.
- overrun_err  out  1  sticky: tick arrived while busy.
- timeout_err  out  1  sticky: pid_done never arrived.

Behaviour:
- Reset: CS=1, Clock_Muestreo=1, adc_sample=0, duty=0, all pulses/flags 0, state IDLE, counters 0.
- IDLE: tick counter held at 0; start=1 → WAIT_TICK next clock.
- Tick counter counts 0..SAMPLE_PERIOD-1 while start=1 and issues a tick at terminal count. First tick occurs SAMPLE_PERIOD clocks after entering WAIT_TICK.
- WAIT_TICK + tick → CONVERT. CS falls on the clock after the tick.
- CONVERT:
  - Clock_Muestreo toggles every CLK_DIV clocks, starting with a falling edge CLK_DIV clocks after CS falls; 16 full periods total.
  - data_ADC is sampled on each internal rising edge. Bits 1–4 are leading zeros and are discarded; bits 5–16 form adc_sample[11:0], MSB first.
  - After the 16th rising edge, CS=1 next clock and Clock_Muestreo stays high.
  - Same clock: adc_sample loads, sample_valid=1, pid_start=1 → PID_WAIT.
  - Frame length tick→CS high = 32*CLK_DIV+1 clocks.
- PID_WAIT:
  - pid_done=1 (including the first cycle after pid_start) → duty loads on the next clock and duty_valid pulses → WAIT_TICK.
  - Saturation: IPD<0 → 0; IPD>4095 → 4095; else IPD[11:0].
  - PID_TIMEOUT clocks without pid_done → timeout_err=1, duty unchanged → WAIT_TICK.
  - pid_done outside PID_WAIT is ignored.
- A tick while state≠WAIT_TICK sets overrun_err. The tick is dropped and the tick counter keeps running.
- start falling in any state: next clock state=IDLE, CS=1, Clock_Muestreo=1, no sample_valid or duty_valid. Partial sample is discarded; duty and adc_sample are held. Flags clear on start 0→1 transition or Reset.
- Reset asserted mid-frame: outputs return to reset values immediately (asynchronous).

Optional Feature:
- LEADZERO_CHECK_EN defined:
  - Adds output lead_err (1 bit, sticky, same clear rules as other flags).
  - Any of the 4 leading bits sampled as 1 sets lead_err and suppresses that frame's sample_valid/pid_start/adc_sample update; the sequencer returns to WAIT_TICK.
- Undefined: port absent; leading bits ignored unconditionally.

Test Plan:
- CLK_DIV=1, SAMPLE_PERIOD=100, PID model returns IPD=18'd1234 2 clocks after pid_start; serial word 0000_1010_1011_1100 → adc_sample=12'hABC, sample_valid once, duty=12'd1234 with one duty_valid, CS low exactly 32 clocks per frame.
- IPD=-5 (18'h3FFFB) → duty=0; IPD=18'd5000 → duty=4095.
- PID model never asserts pid_done, PID_TIMEOUT=64 → timeout_err=1 after 64 clocks, duty keeps previous value, next tick starts a new frame.
- SAMPLE_PERIOD=20 (< frame length) → overrun_err=1, frames never overlap, CS pulses stay well-formed.
- start dropped at the 8th Clock_Muestreo edge → CS=1 next clock, no sample_valid; start re-raised → flags clear, normal frame after SAMPLE_PERIOD.
- LEADZERO_CHECK_EN, leading bits 0100 → lead_err=1, no pid_start, adc_sample unchanged.
